// File: rtl/jtag_ir_loader.sv
// jtag_ir_loader: drives a target TAP through reset/init and IR loads, predicting its state.
// TMS/TDI are registered; tap_state tracks the target using the TMS value present before each edge.
module jtag_ir_loader #(
    parameter int IR_MAX = 8
) (
    input  logic              clk,
    input  logic              TRST_n,
    input  logic              start,
    input  logic [IR_MAX-1:0] ir_data,
    input  logic [3:0]        ir_len,
    input  logic              tap_reset,
    input  logic              TDO,
    output logic              TMS,
    output logic              TDI,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [3:0]        tap_state,
    output logic [IR_MAX-1:0] ir_capture
);
    localparam int IW = $clog2(IR_MAX + 1);
    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL = 4'd2, CAP = 4'd3, SHF = 4'd4,
                           EX1 = 4'd5, PAU = 4'd6, EX2 = 4'd7, UPD = 4'd8;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD} ctl_t;

    ctl_t              ctl;
    logic [2:0]        cnt;
    logic [IW-1:0]     idx, nidx, len_q, len_n;
    logic [IR_MAX-1:0] data_q;
    logic [3:0]        nt;

    assign busy  = ~ready;
    assign len_n = ir_len == 4'd0 ? IW'(1) : (32'(ir_len) > IR_MAX) ? IW'(IR_MAX) : IW'(ir_len);
    // Shift index of the Shift_IR cycle that the coming edge enters.
    assign nidx  = tap_state == SHF ? idx + IW'(1) : '0;

    always_comb begin
        nt = TLR;
        case (tap_state)
            TLR:     nt = TMS ? TLR : RTI;
            RTI:     nt = TMS ? SEL : RTI;
            SEL:     nt = TMS ? TLR : CAP;
            CAP:     nt = TMS ? EX1 : SHF;
            SHF:     nt = TMS ? EX1 : SHF;
            EX1:     nt = TMS ? UPD : PAU;
            PAU:     nt = TMS ? EX2 : PAU;
            EX2:     nt = TMS ? UPD : SHF;
            UPD:     nt = TMS ? SEL : RTI;
            default: nt = TLR;
        endcase
    end

    always_ff @(posedge clk or negedge TRST_n) begin
        if (!TRST_n) begin
            ctl        <= S_INIT;
            cnt        <= '0;
            TMS        <= 1'b1;
            TDI        <= 1'b0;
            ready      <= 1'b0;
            done       <= 1'b0;
            tap_state  <= TLR;
            ir_capture <= '0;
            idx        <= '0;
            data_q     <= '0;
            len_q      <= IW'(1);
        end else begin
            tap_state <= nt;
            done      <= 1'b0;
            TDI       <= 1'b0;
            if (tap_state > UPD) begin
                ctl   <= S_INIT;
                cnt   <= '0;
                TMS   <= 1'b1;
                ready <= 1'b0;
            end else begin
                case (ctl)
                    S_INIT: begin
                        if (cnt == 3'd5) begin
                            ctl   <= S_IDLE;
                            ready <= 1'b1;
                            TMS   <= 1'b0;
                        end else begin
                            cnt <= cnt + 3'd1;
                            TMS <= cnt != 3'd4;
                        end
                    end
                    S_IDLE: begin
                        TMS <= 1'b0;
                        if (tap_reset) begin
                            ctl   <= S_INIT;
                            cnt   <= '0;
                            TMS   <= 1'b1;
                            ready <= 1'b0;
                        end else if (start) begin
                            ctl        <= S_LOAD;
                            data_q     <= ir_data;
                            len_q      <= len_n;
                            ir_capture <= '0;
                            TMS        <= 1'b1;
                            ready      <= 1'b0;
                        end
                    end
                    default: begin
                        if (tap_state == SHF)
                            ir_capture[idx] <= TDO;
                        idx <= nidx;
                        TMS <= nt == EX1 || (nt == SHF && nidx == len_q - IW'(1));
                        TDI <= nt == SHF ? data_q[nidx] : 1'b0;
                        if (nt == RTI) begin
                            ctl   <= S_IDLE;
                            ready <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtag_ir_loader.sv
// tb_jtag_ir_loader: scoreboard bench; expected per-cycle {TMS,TDI,tap_state,done,ready,busy} queued at stimulus time.
module tb_jtag_ir_loader;
    localparam int IR_MAX = 8;

    logic              clk = 1'b0, TRST_n = 1'b0, start = 1'b0, tap_reset = 1'b0;
    logic              tdo_tie = 1'b1, tdo_val = 1'b0;
    logic [IR_MAX-1:0] ir_data = '0;
    logic [3:0]        ir_len = '0;
    logic              TDO, TMS, TDI, ready, busy, done;
    logic [3:0]        tap_state;
    logic [IR_MAX-1:0] ir_capture;
    logic [8:0]        obs, e;
    logic [8:0]        sb[$];
    int                checks = 0, failures = 0;

    assign TDO = tdo_tie ? TDI : tdo_val;
    assign obs = {TMS, TDI, tap_state, done, ready, busy};

    always #5 clk = ~clk;

    jtag_ir_loader #(.IR_MAX(IR_MAX)) dut (
        .clk(clk), .TRST_n(TRST_n), .start(start), .ir_data(ir_data), .ir_len(ir_len),
        .tap_reset(tap_reset), .TDO(TDO), .TMS(TMS), .TDI(TDI), .ready(ready), .busy(busy),
        .done(done), .tap_state(tap_state), .ir_capture(ir_capture)
    );

    function automatic logic [8:0] ent(input logic tms, input logic tdi, input logic [3:0] tap,
                                       input logic dn, input logic rdy);
        return {tms, tdi, tap, dn, rdy, ~rdy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Seven observations: after release/accept, then after each of the six init edges.
    task automatic push_init(input bit from_idle);
        for (int i = 0; i < 7; i++)
            sb.push_back(ent(i < 5, 1'b0,
                             i == 6 ? 4'd1 : (from_idle && i == 0) ? 4'd1 : (from_idle && i == 1) ? 4'd2 : 4'd0,
                             1'b0, i == 6));
    endtask

    task automatic push_load(input logic [7:0] d, input int l);
        sb.push_back(ent(1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
        sb.push_back(ent(1'b0, 1'b0, 4'd2, 1'b0, 1'b0));
        sb.push_back(ent(1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
        for (int k = 0; k < l; k++)
            sb.push_back(ent(k == l - 1, d[k], 4'd4, 1'b0, 1'b0));
        sb.push_back(ent(1'b1, 1'b0, 4'd5, 1'b0, 1'b0));
        sb.push_back(ent(1'b0, 1'b0, 4'd8, 1'b0, 1'b0));
        sb.push_back(ent(1'b0, 1'b0, 4'd1, 1'b1, 1'b1));
    endtask

    task automatic launch(input logic [7:0] d, input logic [3:0] len, input logic tr);
        ir_data = d;
        ir_len = len;
        start = 1'b1;
        tap_reset = tr;
        tick();
        start = 1'b0;
        tap_reset = 1'b0;
    endtask

    task automatic test_reset();
        TRST_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (obs !== ent(1'b1, 1'b0, 4'd0, 1'b0, 1'b0) || ir_capture !== 8'h00) begin
            failures++;
            $display("FAIL reset_values got=%b cap=%h exp=%b cap=00", obs, ir_capture, ent(1'b1, 1'b0, 4'd0, 1'b0, 1'b0));
        end
        TRST_n = 1'b1;
        #1;
        push_init(1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL init_seq cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (sb.size() > 0) tick();
        end
    endtask

    task automatic test_load_a5();
        tdo_tie = 1'b1;
        push_load(8'hA5, 8);
        sb.push_back(ent(1'b0, 1'b0, 4'd1, 1'b0, 1'b1));
        launch(8'hA5, 4'd8, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL load_a5 cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (sb.size() > 0) tick();
        end
        checks++;
        if (ir_capture !== 8'hA5) begin
            failures++;
            $display("FAIL load_a5_capture got=%h exp=a5", ir_capture);
        end
    endtask

    task automatic test_len0();
        tdo_tie = 1'b0;
        tdo_val = 1'b1;
        push_load(8'h01, 1);
        launch(8'h01, 4'd0, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL len0 cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (sb.size() > 0) tick();
        end
        checks++;
        if (ir_capture !== 8'h01) begin
            failures++;
            $display("FAIL len0_capture got=%h exp=01", ir_capture);
        end
        tdo_tie = 1'b1;
    endtask

    task automatic test_start_while_busy();
        push_load(8'h3C, 8);
        sb.push_back(ent(1'b0, 1'b0, 4'd1, 1'b0, 1'b1));
        launch(8'h3C, 4'd8, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL busy_ignore cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (c == 4) begin start = 1'b1; ir_data = 8'hFF; ir_len = 4'd3; end
            if (c == 5) start = 1'b0;
            if (c == 7) tap_reset = 1'b1;
            if (c == 8) tap_reset = 1'b0;
            if (sb.size() > 0) tick();
        end
        checks++;
        if (ir_capture !== 8'h3C) begin
            failures++;
            $display("FAIL busy_ignore_capture got=%h exp=3c", ir_capture);
        end
    endtask

    task automatic test_tap_reset();
        push_init(1'b1);
        sb.push_back(ent(1'b0, 1'b0, 4'd1, 1'b0, 1'b1));
        launch(8'h5A, 4'd8, 1'b1);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL tap_reset_wins cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (sb.size() > 0) tick();
        end
        checks++;
        if (ir_capture !== 8'h3C) begin
            failures++;
            $display("FAIL tap_reset_capture got=%h exp=3c", ir_capture);
        end
    endtask

    task automatic test_len_variants();
        logic [7:0] d_t[3]   = '{8'h96, 8'hFF, 8'h5A};
        logic [3:0] len_t[3] = '{4'd15, 4'd3, 4'd9};
        int         l_t[3]   = '{8, 3, 8};
        logic       tie_t[3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] cap_t[3] = '{8'h96, 8'h07, 8'h5A};
        for (int t = 0; t < 3; t++) begin
            tdo_tie = tie_t[t];
            tdo_val = 1'b1;
            push_load(d_t[t], l_t[t]);
            launch(d_t[t], len_t[t], 1'b0);
            for (int c = 0; sb.size() > 0; c++) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL len_variant%0d cyc=%0d got=%b exp=%b", t, c, obs, e);
                end
                if (sb.size() > 0) tick();
            end
            checks++;
            if (ir_capture !== cap_t[t]) begin
                failures++;
                $display("FAIL len_variant%0d_capture got=%h exp=%h", t, ir_capture, cap_t[t]);
            end
        end
        tdo_tie = 1'b1;
    endtask

    task automatic test_back_to_back();
        push_load(8'hC3, 8);
        push_load(8'h0F, 4);
        launch(8'hC3, 4'd8, 1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (c == 13) begin start = 1'b1; ir_data = 8'h0F; ir_len = 4'd4; end
            if (c == 14) start = 1'b0;
            if (sb.size() > 0) tick();
        end
        checks++;
        if (ir_capture !== 8'h0F) begin
            failures++;
            $display("FAIL back_to_back_capture got=%h exp=0f", ir_capture);
        end
    endtask

    task automatic test_trst_abort();
        push_load(8'hFF, 8);
        launch(8'hFF, 4'd8, 1'b0);
        for (int c = 0; c < 6; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_prefix cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (c < 5) tick();
        end
        sb.delete();
        TRST_n = 1'b0;
        #1;
        checks++;
        if (obs !== ent(1'b1, 1'b0, 4'd0, 1'b0, 1'b0) || ir_capture !== 8'h00) begin
            failures++;
            $display("FAIL abort_async got=%b cap=%h exp=%b cap=00", obs, ir_capture, ent(1'b1, 1'b0, 4'd0, 1'b0, 1'b0));
        end
        repeat (2) tick();
        TRST_n = 1'b1;
        #1;
        push_init(1'b0);
        for (int c = 0; sb.size() > 0; c++) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_reinit cyc=%0d got=%b exp=%b", c, obs, e);
            end
            if (sb.size() > 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_a5();
        test_len0();
        test_start_while_busy();
        test_tap_reset();
        test_len_variants();
        test_back_to_back();
        test_trst_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
